control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hardwired Moore FSM directly upstream of the Mini-SRC datapath: fetches, decodes IR_contents, drives every datapath strobe.
//  Consumes IR_contents and CON_output; produces op_sel, the *_rd / *_out enables, S&E selects, memory Read/Write.
// PARAMETERS
//  OPSEL_W     13  width of one-hot ALU op_sel
//  DIV_CYCLES  32  clocks the ALU divider needs after reset_div before Zhi/Zlo are valid (>=1)
// PORTS
//  clk          in   1   rising-edge clock, sole clock domain
//  clr          in   1   asynchronous, active-low reset
//  stop         in   1   request halt at next instruction boundary
//  IR_contents  in   32  IR: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//  CON_output   in   1   branch condition from CON_FF
//  dp_clr       out  1   synchronous clear to datapath registers
//  run          out  1   1 while executing, 0 in RESET/HALT
//  op_sel       out  13  one-hot ALU op
//  IncPC,Read,Write,Gra,Grb,Grc,BAout,Rin,R_out,CONin,reset_div          out 1 each
//  MDR_rd,MAR_rd,HI_rd,LO_rd,Z_rd,PC_rd,Out_rd,Y_rd,IR_rd                  out 1 each
//  MDR_out,HI_out,LO_out,Zhi_out,Zlo_out,PC_out,Inport_out,C_out           out 1 each
// BEHAVIOUR
//  Outputs decoded combinationally from registered state (+ latched IR/CON); at most one *_out high per cycle.
//  clr low: state=RESET at once, every output 0 except dp_clr. RESET lasts 1 clk after clr rises (dp_clr=1), then T0.
//  Fetch: T0 PC_out,MAR_rd,IncPC | T1 Read,MDR_rd | T2 MDR_out,IR_rd | T3 decode op.
//  R-ALU add..rol: T3 Grb,R_out,Y_rd | T4 Grc,R_out,op,Z_rd | T5 Zlo_out,Gra,Rin.
//  addi/andi/ori: as R-ALU, T4 uses C_out instead of Grc,R_out.
//  ld: T3 Grb,BAout,Y_rd | T4 C_out,ADD,Z_rd | T5 Zlo_out,MAR_rd | T6 Read,MDR_rd | T7 MDR_out,Gra,Rin.
//  ldi: T3-T4 as ld | T5 Zlo_out,Gra,Rin.   st: T3-T5 as ld | T6 Gra,R_out,MDR_rd | T7 Write.
//  mul: T3 Gra,R_out,Y_rd | T4 Grb,R_out,MUL,Z_rd | T5 Zlo_out,LO_rd | T6 Zhi_out,HI_rd.
//  div: T3 as mul | T4 Grb,R_out,DIV,reset_div (1 clk) | DWAIT holds Grb,R_out,DIV for DIV_CYCLES clks,
//   Z_rd on last | then LO/HI as mul T5/T6. 6-bit down-counter; no wrap.
//  neg/not: T3 Grb,R_out,op,Z_rd | T4 Zlo_out,Gra,Rin.
//  br: T3 Gra,R_out,CONin | T4 PC_out,Y_rd | T5 C_out,ADD,Z_rd | T6 Zlo_out,PC_rd only if CON_output=1, else idle.
//  jr: T3 Gra,R_out,PC_rd.   jal: T3 PC_out,Grb,Rin (rb field=15) | T4 Gra,R_out,PC_rd.
//  in: T3 Inport_out,Gra,Rin. out: T3 Gra,R_out,Out_rd. mfhi/mflo: T3 HI_out/LO_out,Gra,Rin.
//  nop and undefined opcodes: T3 no strobes. Every instruction's last step returns to T0.
//  halt: HALT, run=0, all outputs 0, exit only via clr.
//  stop sampled only on entry to T0 -> HALT instead of T0; mid-instruction stop completes the instruction.
//  clr mid-instruction: aborts immediately, no partial strobes after the edge; restart via RESET.
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: extra input step (1b); FSM waits in T0 with all outputs 0 until a step
//   rising edge (registered detect), then runs exactly one instruction. Undefined: no port, free-running.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams ld=00000 ldi=00001 st=00010 add=00011 sub=00100 and=00101 or=00110
//   shr=00111 shra=01000 shl=01001 ror=01010 rol=01011 addi=01100 andi=01101 ori=01110 mul=01111 div=10000
//   neg=10001 not=10010 br=10011 jr=10100 jal=10101 in=10110 out=10111 mfhi=11000 mflo=11001 nop=11010 halt=11011;
//   op_sel bits ADD0 SUB1 AND2 OR3 SHR4 SHRA5 SHL6 ROR7 ROL8 MUL9 DIV10 NEG11 NOT12; state encoding.
//  Sub-module ctrl_out_decode: pure combinational state+opcode -> strobe map; FSM/counter stay in top.
// TESTING
//  Reset: clr low during ld T6 -> all outputs 0, dp_clr=1; release -> 1 clk dp_clr, then PC_out|MAR_rd|IncPC.
//  add r3,r1,r2 (IR=0x19890000) -> T3 Grb|R_out|Y_rd, T4 Grc|R_out|op_sel=13'h0001|Z_rd, T5 Zlo_out|Gra|Rin, T0.
//  br (op 10011), CON_output=0 -> T6 no strobes; CON_output=1 -> T6 Zlo_out|PC_rd.
//  div, DIV_CYCLES=32 -> reset_div high exactly 1 clk at T4; Z_rd 32 clks later; LO_rd then HI_rd; 40 clks T0..T0.
//  stop=1 at st T5 -> st completes incl. Write at T7; next state HALT, run=0; halt op (0xD8000000) same.
//  CTRL_SINGLE_STEP_EN: no step -> T0 held 100 clks, outputs 0; one step pulse -> exactly one instruction.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the Mini-SRC hardwired control unit.
//   - opcode values (IR[31:27])
//   - one-hot op_sel bit positions for the ALU
//   - FSM state encoding, instruction classes, packed strobe bundle
//   - helpers: opcode -> class, class -> final step, opcode -> ALU select
package ctrl_pkg;

  localparam int OP_SEL_BITS = 13;
  localparam int CNT_W       = 6;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int SEL_ADD  = 0;
  localparam int SEL_SUB  = 1;
  localparam int SEL_AND  = 2;
  localparam int SEL_OR   = 3;
  localparam int SEL_SHR  = 4;
  localparam int SEL_SHRA = 5;
  localparam int SEL_SHL  = 6;
  localparam int SEL_ROR  = 7;
  localparam int SEL_ROL  = 8;
  localparam int SEL_MUL  = 9;
  localparam int SEL_DIV  = 10;
  localparam int SEL_NEG  = 11;
  localparam int SEL_NOT  = 12;

  typedef enum logic [3:0] {
    ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    ST_DWAIT, ST_HALT
  } ctrl_state_e;

  typedef enum logic [4:0] {
    CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MUL, CL_DIV, CL_UNARY, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } op_class_e;

  typedef struct packed {
    logic inc_pc, read, write, gra, grb, grc, ba_out, rin, r_out, con_in, reset_div;
    logic mdr_rd, mar_rd, hi_rd, lo_rd, z_rd, pc_rd, out_rd, y_rd, ir_rd;
    logic mdr_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, inport_out, c_out;
    logic [OP_SEL_BITS-1:0] op_sel;
  } ctrl_strb_t;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: c = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: c = CL_IMM;
      OP_LD:   c = CL_LD;
      OP_LDI:  c = CL_LDI;
      OP_ST:   c = CL_ST;
      OP_MUL:  c = CL_MUL;
      OP_DIV:  c = CL_DIV;
      OP_NEG, OP_NOT: c = CL_UNARY;
      OP_BR:   c = CL_BR;
      OP_JR:   c = CL_JR;
      OP_JAL:  c = CL_JAL;
      OP_IN:   c = CL_IN;
      OP_OUT:  c = CL_OUT;
      OP_MFHI: c = CL_MFHI;
      OP_MFLO: c = CL_MFLO;
      OP_HALT: c = CL_HALT;
      default: c = CL_NOP;
    endcase
    return c;
  endfunction

  // Index of the final T-step for each class (div counts its T5/T6 after DWAIT).
  function automatic logic [2:0] last_step(input op_class_e c);
    logic [2:0] n;
    case (c)
      CL_ALU, CL_IMM, CL_LDI:    n = 3'd5;
      CL_LD, CL_ST:              n = 3'd7;
      CL_MUL, CL_DIV, CL_BR:     n = 3'd6;
      CL_UNARY, CL_JAL:          n = 3'd4;
      default:                   n = 3'd3;
    endcase
    return n;
  endfunction

  function automatic logic [OP_SEL_BITS-1:0] alu_sel(input logic [4:0] op);
    logic [OP_SEL_BITS-1:0] s;
    s = '0;
    case (op)
      OP_ADD, OP_ADDI: s[SEL_ADD]  = 1'b1;
      OP_SUB:          s[SEL_SUB]  = 1'b1;
      OP_AND, OP_ANDI: s[SEL_AND]  = 1'b1;
      OP_OR, OP_ORI:   s[SEL_OR]   = 1'b1;
      OP_SHR:          s[SEL_SHR]  = 1'b1;
      OP_SHRA:         s[SEL_SHRA] = 1'b1;
      OP_SHL:          s[SEL_SHL]  = 1'b1;
      OP_ROR:          s[SEL_ROR]  = 1'b1;
      OP_ROL:          s[SEL_ROL]  = 1'b1;
      OP_NEG:          s[SEL_NEG]  = 1'b1;
      OP_NOT:          s[SEL_NOT]  = 1'b1;
      default:         s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: pure combinational map from FSM state + opcode to the
// datapath strobe bundle.
//   state_i     current FSM state
//   op_i        opcode IR[31:27]
//   con_i       branch condition (only consulted in br T6)
//   t0_go_i     T0 may fetch (tied high unless single-step gating is active)
//   div_last_i  final DWAIT cycle (Z captures divider result)
//   strb_o      strobe bundle, all zero in RESET/HALT
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  ctrl_state_e state_i,
  input  logic [4:0]  op_i,
  input  logic        con_i,
  input  logic        t0_go_i,
  input  logic        div_last_i,
  output ctrl_strb_t  strb_o
);

  op_class_e cls;

  always_comb begin
    strb_o = '0;
    cls    = op_class(op_i);
    case (state_i)
      ST_T0: if (t0_go_i) begin
        strb_o.pc_out = 1'b1; strb_o.mar_rd = 1'b1; strb_o.inc_pc = 1'b1;
      end
      ST_T1: begin strb_o.read = 1'b1; strb_o.mdr_rd = 1'b1; end
      ST_T2: begin strb_o.mdr_out = 1'b1; strb_o.ir_rd = 1'b1; end
      ST_T3: case (cls)
        CL_ALU, CL_IMM: begin strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.y_rd = 1'b1; end
        CL_LD, CL_LDI, CL_ST: begin strb_o.grb = 1'b1; strb_o.ba_out = 1'b1; strb_o.y_rd = 1'b1; end
        CL_MUL, CL_DIV: begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.y_rd = 1'b1; end
        CL_UNARY: begin
          strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.z_rd = 1'b1;
          strb_o.op_sel = alu_sel(op_i);
        end
        CL_BR:   begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.con_in = 1'b1; end
        CL_JR:   begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.pc_rd = 1'b1; end
        CL_JAL:  begin strb_o.pc_out = 1'b1; strb_o.grb = 1'b1; strb_o.rin = 1'b1; end
        CL_IN:   begin strb_o.inport_out = 1'b1; strb_o.gra = 1'b1; strb_o.rin = 1'b1; end
        CL_OUT:  begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.out_rd = 1'b1; end
        CL_MFHI: begin strb_o.hi_out = 1'b1; strb_o.gra = 1'b1; strb_o.rin = 1'b1; end
        CL_MFLO: begin strb_o.lo_out = 1'b1; strb_o.gra = 1'b1; strb_o.rin = 1'b1; end
        default: strb_o = '0;
      endcase
      ST_T4: case (cls)
        CL_ALU: begin
          strb_o.grc = 1'b1; strb_o.r_out = 1'b1; strb_o.z_rd = 1'b1;
          strb_o.op_sel = alu_sel(op_i);
        end
        CL_IMM: begin strb_o.c_out = 1'b1; strb_o.z_rd = 1'b1; strb_o.op_sel = alu_sel(op_i); end
        CL_LD, CL_LDI, CL_ST: begin
          strb_o.c_out = 1'b1; strb_o.z_rd = 1'b1; strb_o.op_sel[SEL_ADD] = 1'b1;
        end
        CL_MUL: begin
          strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.z_rd = 1'b1;
          strb_o.op_sel[SEL_MUL] = 1'b1;
        end
        CL_DIV: begin
          strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.reset_div = 1'b1;
          strb_o.op_sel[SEL_DIV] = 1'b1;
        end
        CL_UNARY: begin strb_o.zlo_out = 1'b1; strb_o.gra = 1'b1; strb_o.rin = 1'b1; end
        CL_BR:    begin strb_o.pc_out = 1'b1; strb_o.y_rd = 1'b1; end
        CL_JAL:   begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.pc_rd = 1'b1; end
        default:  strb_o = '0;
      endcase
      // Divider operands stay on the bus for the whole wait; Z latches only at the end.
      ST_DWAIT: begin
        strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.op_sel[SEL_DIV] = 1'b1;
        strb_o.z_rd = div_last_i;
      end
      ST_T5: case (cls)
        CL_ALU, CL_IMM, CL_LDI: begin strb_o.zlo_out = 1'b1; strb_o.gra = 1'b1; strb_o.rin = 1'b1; end
        CL_LD, CL_ST:   begin strb_o.zlo_out = 1'b1; strb_o.mar_rd = 1'b1; end
        CL_MUL, CL_DIV: begin strb_o.zlo_out = 1'b1; strb_o.lo_rd = 1'b1; end
        CL_BR: begin strb_o.c_out = 1'b1; strb_o.z_rd = 1'b1; strb_o.op_sel[SEL_ADD] = 1'b1; end
        default: strb_o = '0;
      endcase
      ST_T6: case (cls)
        CL_LD:          begin strb_o.read = 1'b1; strb_o.mdr_rd = 1'b1; end
        CL_ST:          begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.mdr_rd = 1'b1; end
        CL_MUL, CL_DIV: begin strb_o.zhi_out = 1'b1; strb_o.hi_rd = 1'b1; end
        CL_BR:          begin strb_o.zlo_out = con_i; strb_o.pc_rd = con_i; end
        default: strb_o = '0;
      endcase
      ST_T7: case (cls)
        CL_LD:   begin strb_o.mdr_out = 1'b1; strb_o.gra = 1'b1; strb_o.rin = 1'b1; end
        CL_ST:   strb_o.write = 1'b1;
        default: strb_o = '0;
      endcase
      default: strb_o = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini-SRC datapath.
// Fetches, decodes IR_contents[31:27] and drives every datapath strobe.
//   clk, clr (async active-low), stop (halt at next instruction boundary)
//   IR_contents, CON_output       latched IR / branch condition from datapath
//   dp_clr, run                   datapath clear, executing flag
//   op_sel                        one-hot ALU op
//   remaining outputs             register/bus/memory strobes
// Build option: define CTRL_SINGLE_STEP_EN to add input 'step'; the FSM then
// idles in T0 (outputs 0) until a step rising edge and runs one instruction.
//
// state    | meaning
// RESET    | clr asserted or first clock after release, dp_clr high
// T0..T2   | fetch: PC->MAR, memory read, MDR->IR
// T3..T7   | execute steps, count depends on instruction class
// DWAIT    | div only: hold operands DIV_CYCLES clocks, Z_rd on last
// HALT     | halted, all outputs 0, left only through clr
module control_unit
  import ctrl_pkg::*;
#(
  parameter int OPSEL_W    = 13,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               stop,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [31:0]        IR_contents,
  input  logic               CON_output,
  output logic               dp_clr,
  output logic               run,
  output logic [OPSEL_W-1:0] op_sel,
  output logic IncPC, Read, Write, Gra, Grb, Grc, BAout, Rin, R_out, CONin, reset_div,
  output logic MDR_rd, MAR_rd, HI_rd, LO_rd, Z_rd, PC_rd, Out_rd, Y_rd, IR_rd,
  output logic MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, Inport_out, C_out
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op;
  op_class_e        cls;
  logic [2:0]       last;
  logic             t0_go, div_last;
  ctrl_state_e      boundary;
  ctrl_strb_t       strb;
  logic             ir_unused;

  assign op        = IR_contents[31:27];
  assign ir_unused = ^IR_contents[26:0];
  assign cls       = op_class(op);
  assign last      = last_step(cls);
  // Terminal count at 1 so Z_rd lands on the DIV_CYCLES-th wait cycle; 0 is a safety exit.
  assign div_last  = (state_q == ST_DWAIT) && (cnt_q <= CNT_W'(1));
  // stop is only looked at when an instruction boundary is reached.
  assign boundary  = stop ? ST_HALT : ST_T0;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q1, step_q2;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_q1 <= 1'b0;
      step_q2 <= 1'b0;
    end else begin
      step_q1 <= step;
      step_q2 <= step_q1;
    end
  end
  assign t0_go = step_q1 & ~step_q2;
`else
  assign t0_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: state_d = boundary;
      ST_T0:    if (t0_go) state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        if (cls == CL_HALT)     state_d = ST_HALT;
        else if (last == 3'd3)  state_d = boundary;
        else                    state_d = ST_T4;
      end
      ST_T4: begin
        if (cls == CL_DIV) begin
          state_d = ST_DWAIT;
          cnt_d   = DIV_LOAD;
        end else if (last == 3'd4) begin
          state_d = boundary;
        end else begin
          state_d = ST_T5;
        end
      end
      ST_DWAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (div_last)    state_d = ST_T5;
      end
      ST_T5:   state_d = (last == 3'd5) ? boundary : ST_T6;
      ST_T6:   state_d = (last == 3'd6) ? boundary : ST_T7;
      ST_T7:   state_d = boundary;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  ctrl_out_decode u_decode (
    .state_i    (state_q),
    .op_i       (op),
    .con_i      (CON_output),
    .t0_go_i    (t0_go),
    .div_last_i (div_last),
    .strb_o     (strb)
  );

  assign dp_clr     = (state_q == ST_RESET);
  assign run        = (state_q != ST_RESET) && (state_q != ST_HALT);
  assign op_sel     = OPSEL_W'(strb.op_sel);
  assign IncPC      = strb.inc_pc;
  assign Read       = strb.read;
  assign Write      = strb.write;
  assign Gra        = strb.gra;
  assign Grb        = strb.grb;
  assign Grc        = strb.grc;
  assign BAout      = strb.ba_out;
  assign Rin        = strb.rin;
  assign R_out      = strb.r_out;
  assign CONin      = strb.con_in;
  assign reset_div  = strb.reset_div;
  assign MDR_rd     = strb.mdr_rd;
  assign MAR_rd     = strb.mar_rd;
  assign HI_rd      = strb.hi_rd;
  assign LO_rd      = strb.lo_rd;
  assign Z_rd       = strb.z_rd;
  assign PC_rd      = strb.pc_rd;
  assign Out_rd     = strb.out_rd;
  assign Y_rd       = strb.y_rd;
  assign IR_rd      = strb.ir_rd;
  assign MDR_out    = strb.mdr_out;
  assign HI_out     = strb.hi_out;
  assign LO_out     = strb.lo_out;
  assign Zhi_out    = strb.zhi_out;
  assign Zlo_out    = strb.zlo_out;
  assign PC_out     = strb.pc_out;
  assign Inport_out = strb.inport_out;
  assign C_out      = strb.c_out;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam int DIV_CYC = 32;

  localparam int INCPC = 0, READ = 1, WRITE = 2, GRA = 3, GRB = 4, GRC = 5, BAOUT = 6;
  localparam int RIN = 7, ROUT = 8, CONIN = 9, RSTDIV = 10, MDRRD = 11, MARRD = 12;
  localparam int HIRD = 13, LORD = 14, ZRD = 15, PCRD = 16, OUTRD = 17, YRD = 18, IRRD = 19;
  localparam int MDROUT = 20, HIOUT = 21, LOOUT = 22, ZHIOUT = 23, ZLOOUT = 24, PCOUT = 25;
  localparam int INOUT = 26, COUT = 27, DPCLR = 28, RUN = 29;

  logic clk, clr, stop, step, CON_output;
  logic [31:0] IR_contents;
  logic dp_clr, run;
  logic [12:0] op_sel;
  logic IncPC, Read, Write, Gra, Grb, Grc, BAout, Rin, R_out, CONin, reset_div;
  logic MDR_rd, MAR_rd, HI_rd, LO_rd, Z_rd, PC_rd, Out_rd, Y_rd, IR_rd;
  logic MDR_out, HI_out, LO_out, Zhi_out, Zlo_out, PC_out, Inport_out, C_out;

  int checks = 0;
  int errors = 0;
  logic [63:0] obs;
  logic [63:0] exp_q[$];

  control_unit #(.OPSEL_W(13), .DIV_CYCLES(DIV_CYC)) dut (
    .clk(clk), .clr(clr), .stop(stop),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .IR_contents(IR_contents), .CON_output(CON_output),
    .dp_clr(dp_clr), .run(run), .op_sel(op_sel),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .BAout(BAout), .Rin(Rin), .R_out(R_out), .CONin(CONin), .reset_div(reset_div),
    .MDR_rd(MDR_rd), .MAR_rd(MAR_rd), .HI_rd(HI_rd), .LO_rd(LO_rd), .Z_rd(Z_rd),
    .PC_rd(PC_rd), .Out_rd(Out_rd), .Y_rd(Y_rd), .IR_rd(IR_rd),
    .MDR_out(MDR_out), .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out),
    .Zlo_out(Zlo_out), .PC_out(PC_out), .Inport_out(Inport_out), .C_out(C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs = '0;
    obs[INCPC] = IncPC;   obs[READ] = Read;     obs[WRITE] = Write;   obs[GRA] = Gra;
    obs[GRB] = Grb;       obs[GRC] = Grc;       obs[BAOUT] = BAout;   obs[RIN] = Rin;
    obs[ROUT] = R_out;    obs[CONIN] = CONin;   obs[RSTDIV] = reset_div;
    obs[MDRRD] = MDR_rd;  obs[MARRD] = MAR_rd;  obs[HIRD] = HI_rd;    obs[LORD] = LO_rd;
    obs[ZRD] = Z_rd;      obs[PCRD] = PC_rd;    obs[OUTRD] = Out_rd;  obs[YRD] = Y_rd;
    obs[IRRD] = IR_rd;    obs[MDROUT] = MDR_out; obs[HIOUT] = HI_out; obs[LOOUT] = LO_out;
    obs[ZHIOUT] = Zhi_out; obs[ZLOOUT] = Zlo_out; obs[PCOUT] = PC_out;
    obs[INOUT] = Inport_out; obs[COUT] = C_out; obs[DPCLR] = dp_clr; obs[RUN] = run;
    obs[44:32] = op_sel;
  end

  function automatic logic [63:0] m(input int b);
    return 64'd1 << b;
  endfunction

  function automatic logic [63:0] osel(input int b);
    return 64'd1 << (32 + b);
  endfunction

  // Expected per-cycle strobe sets for one instruction, T0 onwards, straight from the step tables.
  task automatic build_exp(input logic [4:0] op, input logic con);
    logic [63:0] r, a;
    r = m(RUN);
    exp_q.delete();
    exp_q.push_back(r | m(PCOUT) | m(MARRD) | m(INCPC));
    exp_q.push_back(r | m(READ) | m(MDRRD));
    exp_q.push_back(r | m(MDROUT) | m(IRRD));
    if (op >= 5'd3 && op <= 5'd11) begin
      a = osel(int'(op) - 3);
      exp_q.push_back(r | m(GRB) | m(ROUT) | m(YRD));
      exp_q.push_back(r | m(GRC) | m(ROUT) | a | m(ZRD));
      exp_q.push_back(r | m(ZLOOUT) | m(GRA) | m(RIN));
    end else if (op >= 5'd12 && op <= 5'd14) begin
      a = osel(op == 5'd12 ? 0 : (op == 5'd13 ? 2 : 3));
      exp_q.push_back(r | m(GRB) | m(ROUT) | m(YRD));
      exp_q.push_back(r | m(COUT) | a | m(ZRD));
      exp_q.push_back(r | m(ZLOOUT) | m(GRA) | m(RIN));
    end else begin
      case (op)
        5'd0, 5'd1, 5'd2: begin
          exp_q.push_back(r | m(GRB) | m(BAOUT) | m(YRD));
          exp_q.push_back(r | m(COUT) | osel(0) | m(ZRD));
          if (op == 5'd1) exp_q.push_back(r | m(ZLOOUT) | m(GRA) | m(RIN));
          else begin
            exp_q.push_back(r | m(ZLOOUT) | m(MARRD));
            if (op == 5'd0) begin
              exp_q.push_back(r | m(READ) | m(MDRRD));
              exp_q.push_back(r | m(MDROUT) | m(GRA) | m(RIN));
            end else begin
              exp_q.push_back(r | m(GRA) | m(ROUT) | m(MDRRD));
              exp_q.push_back(r | m(WRITE));
            end
          end
        end
        5'd15, 5'd16: begin
          exp_q.push_back(r | m(GRA) | m(ROUT) | m(YRD));
          if (op == 5'd15) exp_q.push_back(r | m(GRB) | m(ROUT) | osel(9) | m(ZRD));
          else begin
            exp_q.push_back(r | m(GRB) | m(ROUT) | osel(10) | m(RSTDIV));
            for (int k = 1; k <= DIV_CYC; k++)
              exp_q.push_back(r | m(GRB) | m(ROUT) | osel(10) | ((k == DIV_CYC) ? m(ZRD) : 64'd0));
          end
          exp_q.push_back(r | m(ZLOOUT) | m(LORD));
          exp_q.push_back(r | m(ZHIOUT) | m(HIRD));
        end
        5'd17, 5'd18: begin
          exp_q.push_back(r | m(GRB) | m(ROUT) | osel(op == 5'd17 ? 11 : 12) | m(ZRD));
          exp_q.push_back(r | m(ZLOOUT) | m(GRA) | m(RIN));
        end
        5'd19: begin
          exp_q.push_back(r | m(GRA) | m(ROUT) | m(CONIN));
          exp_q.push_back(r | m(PCOUT) | m(YRD));
          exp_q.push_back(r | m(COUT) | osel(0) | m(ZRD));
          exp_q.push_back(con ? (r | m(ZLOOUT) | m(PCRD)) : r);
        end
        5'd20: exp_q.push_back(r | m(GRA) | m(ROUT) | m(PCRD));
        5'd21: begin
          exp_q.push_back(r | m(PCOUT) | m(GRB) | m(RIN));
          exp_q.push_back(r | m(GRA) | m(ROUT) | m(PCRD));
        end
        5'd22: exp_q.push_back(r | m(INOUT) | m(GRA) | m(RIN));
        5'd23: exp_q.push_back(r | m(GRA) | m(ROUT) | m(OUTRD));
        5'd24: exp_q.push_back(r | m(HIOUT) | m(GRA) | m(RIN));
        5'd25: exp_q.push_back(r | m(LOOUT) | m(GRA) | m(RIN));
        default: exp_q.push_back(r);
      endcase
    end
  endtask

  task automatic do_reset();
    clr = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== m(DPCLR)) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, m(DPCLR));
    end
    @(posedge clk);
    #2 clr = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== m(DPCLR)) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, m(DPCLR));
    end
  endtask

  // Called just before the clock edge that enters T0.
  task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                           input int stop_at, input int abort_at);
    logic [63:0] bus;
    build_exp(ir[31:27], con);
    bus = m(ROUT) | m(MDROUT) | m(HIOUT) | m(LOOUT) | m(ZHIOUT) | m(ZLOOUT) |
          m(PCOUT) | m(INOUT) | m(COUT);
    step = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      step = 1'b0;
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", name, i, obs, exp_q[i]);
      end
      checks++;
      if ($countones(obs & bus) > 1) begin
        errors++;
        $display("FAIL %s bus_drivers step %0d: got %h expected at most one driver", name, i, obs & bus);
      end
      if (i == 2) IR_contents = ir;
      if (i == 3) CON_output = con;
      if (i == stop_at) stop = 1'b1;
      if (i == abort_at) begin
        #1 clr = 1'b0;
        #1;
        checks++;
        if (obs !== m(DPCLR)) begin
          errors++;
          $display("FAIL %s abort: got %h expected %h", name, obs, m(DPCLR));
        end
        return;
      end
    end
  endtask

  task automatic check_idle(input string name, input int n, input logic [63:0] expv);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, expv);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    run_instr("ld_abort", {5'b00000, 27'($urandom)}, 1'b0, -1, 6);
    do_reset();
    run_instr("ld_after_reset", {5'b00000, 27'($urandom)}, 1'b0, -1, -1);
  endtask

  task automatic test_add();
    run_instr("add_r3_r1_r2", 32'h1989_0000, 1'b0, -1, -1);
  endtask

  task automatic test_br();
    run_instr("br_con0", {5'b10011, 27'($urandom)}, 1'b0, -1, -1);
    run_instr("br_con1", {5'b10011, 27'($urandom)}, 1'b1, -1, -1);
  endtask

  task automatic test_div();
    run_instr("div", {5'b10000, 27'($urandom)}, 1'b0, -1, -1);
    run_instr("after_div", 32'h1989_0000, 1'b0, -1, -1);
  endtask

  task automatic test_stop();
    run_instr("st_stop", {5'b00010, 27'($urandom)}, 1'b0, 5, -1);
    check_idle("st_halted", 6, 64'd0);
    do_reset();
  endtask

  task automatic test_halt_op();
    run_instr("halt_op", 32'hD800_0000, 1'b0, -1, -1);
    check_idle("halt_op_halted", 10, 64'd0);
    do_reset();
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    check_idle("step_wait", 100, m(RUN));
    run_instr("step_add", 32'h1989_0000, 1'b0, -1, -1);
    check_idle("step_after", 5, m(RUN));
  endtask
`endif

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr("random", {op, 27'($urandom)}, 1'($urandom), -1, -1);
    end
  endtask

  initial begin
    clr = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    CON_output = 1'b0;
    IR_contents = '0;
    test_reset();
    test_add();
    test_br();
    test_div();
    test_stop();
    test_halt_op();
`ifdef CTRL_SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
